// File: rtl/collector_if.sv
// Lane capture handshake and output word stream between the encrypter array
// and the serialiser; the collector drives it through the master modport.
interface collector_if #(
    parameter int NUM_ENC   = 4,
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
);
    localparam int LW = $clog2(NUM_ENC);

    logic [NUM_ENC*WIDTH-1:0] data_in_e;
    logic [NUM_ENC-1:0]       data_ready_e;
    logic [NUM_ENC-1:0]       capture_e;
    logic [WIDTH-1:0]         out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [LW-1:0]            lane_ptr;
    logic                     fifo_full;
    logic [CNT_WIDTH-1:0]     word_count;

    modport master (
        input  data_in_e, data_ready_e, out_ready,
        output capture_e, out_data, out_valid, lane_ptr, fifo_full, word_count
    );

    modport slave (
        output data_in_e, data_ready_e, out_ready,
        input  capture_e, out_data, out_valid, lane_ptr, fifo_full, word_count
    );
endinterface

// File: rtl/collector.sv
// Round-robin four-phase capture of encrypter lanes into a small FWFT FIFO
// that feeds a valid/ready word stream in original dispatch order.
module collector #(
    parameter int NUM_ENC    = 4,
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic       clk,
    input  logic       reset,
    collector_if.master bus
);
    localparam int LW = $clog2(NUM_ENC);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {S_WAIT, S_RELEASE} state_t;

    state_t               r_state;
    logic [LW-1:0]        r_lane;
    logic [NUM_ENC-1:0]   r_cap;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr, r_rptr;
    logic [AW:0]          r_occ;
    logic [WIDTH-1:0]     r_head;
    logic                 r_valid, r_full;

    logic                 w_lane_rdy;
    logic [WIDTH-1:0]     w_lane_data;
    logic                 w_push, w_pop;
    logic [AW:0]          w_occ_nxt;
    logic [AW-1:0]        w_rptr_nxt;
    logic [WIDTH-1:0]     w_head_nxt;

    assign w_lane_rdy  = bus.data_ready_e[r_lane];
    assign w_lane_data = bus.data_in_e[r_lane*WIDTH +: WIDTH];

    // Only the expected lane is ever considered; a full FIFO stalls the lane.
    assign w_push     = (r_state == S_WAIT) && w_lane_rdy && !r_full;
    assign w_pop      = r_valid && bus.out_ready;
    assign w_occ_nxt  = r_occ + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign w_rptr_nxt = w_pop ? r_rptr + AW'(1) : r_rptr;

    // Registered head: when the next head slot is the one being written this
    // edge (empty FIFO, or single entry popped), bypass the incoming word.
    assign w_head_nxt = (w_push && (w_rptr_nxt == r_wptr)) ? w_lane_data : r_mem[w_rptr_nxt];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_lane_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_lane  <= '0;
            r_cap   <= '0;
            r_cnt   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_occ   <= '0;
            r_head  <= '0;
            r_valid <= 1'b0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            r_rptr  <= w_rptr_nxt;
            r_occ   <= w_occ_nxt;
            r_valid <= (w_occ_nxt != '0);
            r_full  <= (w_occ_nxt == (AW+1)'(FIFO_DEPTH));
            if (w_occ_nxt != '0) r_head <= w_head_nxt;

            case (r_state)
                S_WAIT: begin
                    if (w_push) begin
                        r_cap[r_lane] <= 1'b1;
                        r_cnt         <= r_cnt + CNT_WIDTH'(1);
                        r_state       <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // Waiting for ready to fall guarantees no word is taken twice.
                    if (!w_lane_rdy) begin
                        r_cap   <= '0;
                        r_lane  <= r_lane + LW'(1);
                        r_state <= S_WAIT;
                    end
                end
                default: r_state <= S_WAIT;
            endcase
        end
    end

    assign bus.capture_e  = r_cap;
    assign bus.out_data   = r_head;
    assign bus.out_valid  = r_valid;
    assign bus.lane_ptr   = r_lane;
    assign bus.fifo_full  = r_full;
    assign bus.word_count = r_cnt;
endmodule
